dm_ext: RTL and testbench

DM_EXT -- requirements
Module: dm_ext

---
 rtl/dm_ext.sv | 139 +++++++++++++
 tb/tb_dm_ext.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dm_ext.sv
// Byte-addressable big-endian data memory with sized, sign/zero-extending loads.
// Memory is zeroed one word per cycle after every reset; requests are ignored meanwhile.
module dm_ext #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] Data_in,
  input  logic        MemWr,
  input  logic        MemRd,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] Data_out,
  output logic        Rd_valid,
  output logic        Busy,
  output logic        Misalign,
  output logic        OutOfRange
);
  localparam int unsigned Words = DEPTH_BYTES / 4;
  localparam int unsigned Aw    = $clog2(Words);

  typedef enum logic {StClear, StIdle} state_e;

  state_e        state_q, state_d;
  logic [Aw-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]   mem_q [Words];
  logic [31:0]   data_out_q, data_out_d;
  logic          rd_valid_q, rd_valid_d;
  logic          misalign_q, misalign_d;
  logic          oor_q, oor_d;

  logic [31:0]   offset, rd_word, wr_data, ld_data;
  logic [Aw-1:0] word_idx;
  logic [3:0]    wr_be;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          misaligned, in_range, req, do_store, do_load;

  assign Busy       = (state_q == StClear);
  assign Data_out   = data_out_q;
  assign Rd_valid   = rd_valid_q;
  assign Misalign   = misalign_q;
  assign OutOfRange = oor_q;

  always_comb begin
    offset   = Addr - BASE_ADDR;
    in_range = offset < DEPTH_BYTES;
    word_idx = offset[Aw+1:2];
    case (Size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = Addr[0];
      default: misaligned = (Addr[1:0] != 2'b00);
    endcase
    req      = !Busy && (MemWr || MemRd);
    do_store = req && MemWr && !misaligned && in_range;
    do_load  = req && MemRd && !MemWr;

    // Lane 3 (bits 31:24) holds the lowest byte address.
    rd_word = mem_q[word_idx];
    case (offset[1:0])
      2'b00:   ld_byte = rd_word[31:24];
      2'b01:   ld_byte = rd_word[23:16];
      2'b10:   ld_byte = rd_word[15:8];
      default: ld_byte = rd_word[7:0];
    endcase
    ld_half = offset[1] ? rd_word[15:0] : rd_word[31:16];
    case (Size)
      2'b00:   ld_data = {{24{ld_byte[7] & ~Unsigned}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~Unsigned}}, ld_half};
      default: ld_data = rd_word;
    endcase

    case (Size)
      2'b00: begin
        wr_be   = 4'b1000 >> offset[1:0];
        wr_data = {4{Data_in[7:0]}};
      end
      2'b01: begin
        wr_be   = offset[1] ? 4'b0011 : 4'b1100;
        wr_data = {2{Data_in[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = Data_in;
      end
    endcase

    rd_valid_d = do_load;
    data_out_d = data_out_q;
    if (do_load) data_out_d = (misaligned || !in_range) ? 32'h0 : ld_data;
    misalign_d = req && misaligned;
    oor_d      = req && !misaligned && !in_range;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == StClear) begin
      if (clr_cnt_q == Aw'(Words - 1)) begin
        state_d   = StIdle;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      misalign_q <= misalign_d;
      oor_q      <= oor_d;
    end
  end

  // No reset on the array: the clear sequence zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (Busy) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_ext.sv
// Scoreboard bench for dm_ext: a byte-array reference model queues expected responses,
// and a monitor compares them whenever the DUT raises Rd_valid, Misalign or OutOfRange.
module tb_dm_ext;
  localparam int unsigned Depth = 1024;
  localparam logic [31:0] Base  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Addr, Data_in, Data_out;
  logic        MemWr, MemRd, Unsigned, Rd_valid, Busy, Misalign, OutOfRange;
  logic [1:0]  Size;

  always #5 clk = ~clk;

  dm_ext #(.DEPTH_BYTES(Depth), .BASE_ADDR(Base)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .Data_in(Data_in), .MemWr(MemWr), .MemRd(MemRd),
    .Size(Size), .Unsigned(Unsigned), .Data_out(Data_out), .Rd_valid(Rd_valid),
    .Busy(Busy), .Misalign(Misalign), .OutOfRange(OutOfRange)
  );

  typedef struct packed {
    logic        rv;
    logic [31:0] d;
    logic        mis;
    logic        oor;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem_m [Depth];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference behaviour: plain byte array, big-endian assembly, arithmetic extension.
  task automatic model(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit uns);
    int          n;
    logic [31:0] off;
    bit          mis, oor;
    longint      v;
    exp_t        e;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = a - Base;
    mis = (a % n) != 0;
    oor = !mis && (off >= Depth);
    if (!wr && !rd) return;
    if (mis || oor) begin
      e.rv = rd && !wr; e.d = 32'h0; e.mis = mis; e.oor = oor;
      q.push_back(e);
    end else if (wr) begin
      for (int i = 0; i < n; i++) mem_m[off + i] = 8'(d >> (8 * (n - 1 - i)));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + longint'(mem_m[off + i]);
      if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      e.rv = 1'b1; e.d = 32'(v); e.mis = 1'b0; e.oor = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic issue(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit uns);
    model(wr, rd, a, d, sz, uns);
    MemWr = wr; MemRd = rd; Addr = a; Data_in = d; Size = sz; Unsigned = uns;
    @(posedge clk); #1;
    MemWr = 1'b0; MemRd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts edges with Busy high after release; pokes requests that must be ignored.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 3) begin MemRd = 1'b1; Addr = Base; Size = 2'b10; end
      if (n == 6) begin MemRd = 1'b0; MemWr = 1'b1; Data_in = 32'hFFFF_FFFF; end
      if (n == 9) MemWr = 1'b0;
    end while (Busy && n < 2000);
    MemWr = 1'b0; MemRd = 1'b0;
    chk(name, n, 256);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (Rd_valid || Misalign || OutOfRange)) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_output: rv=%b mis=%b oor=%b data=%h, expected none",
                   Rd_valid, Misalign, OutOfRange, Data_out);
        end else begin
          e = q.pop_front();
          chk("rd_valid", 32'(Rd_valid), 32'(e.rv));
          chk("misalign", 32'(Misalign), 32'(e.mis));
          chk("out_of_range", 32'(OutOfRange), 32'(e.oor));
          if (e.rv) chk("data_out", Data_out, e.d);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    bit          wr, rd, uns;
    int          r;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < Depth; i++) mem_m[i] = 8'h00;
    rst = 1'b0; MemWr = 1'b0; MemRd = 1'b0; Addr = '0; Data_in = '0; Size = '0; Unsigned = 1'b0;
    #12;
    chk("reset_busy", 32'(Busy), 1);
    chk("reset_data_out", Data_out, 0);
    chk("reset_rd_valid", 32'(Rd_valid), 0);
    chk("reset_flags", {30'b0, Misalign, OutOfRange}, 0);
    @(negedge clk); rst = 1'b1;
    count_busy("busy_cycles_initial");

    issue(0, 1, Base, 0, 2'b10, 0);
    issue(1, 0, Base + 32'h10, 32'h8192_A3B4, 2'b10, 0);
    issue(0, 1, Base + 32'h10, 0, 2'b00, 0);
    issue(0, 1, Base + 32'h10, 0, 2'b00, 1);
    issue(0, 1, Base + 32'h12, 0, 2'b01, 0);
    issue(1, 0, Base + 32'h11, 32'h0000_007F, 2'b00, 0);
    issue(0, 1, Base + 32'h10, 0, 2'b10, 0);
    issue(0, 1, Base + 32'h2, 0, 2'b10, 0);
    issue(1, 0, Base + 32'h400, 32'hDEAD_BEEF, 2'b10, 0);
    issue(0, 1, Base, 0, 2'b10, 0);
    issue(1, 1, Base + 32'h20, 32'h1234_5678, 2'b10, 0);
    issue(0, 1, Base + 32'h20, 0, 2'b10, 0);
    idle(3);
    chk("data_out_hold", Data_out, 32'h1234_5678);
    chk("idle_rd_valid", 32'(Rd_valid), 0);

    for (int i = 0; i < 1500; i++) begin
      r   = int'($urandom_range(0, 9));
      wr  = (r < 4);
      rd  = (r >= 3) && (r < 8);
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = Base + $urandom_range(Depth - 8, Depth + 16);
      else a = Base + $urandom_range(0, 63);
      if ($urandom_range(0, 31) == 0) a = $urandom;
      issue(wr, rd, a, $urandom, sz, uns);
    end
    idle(2);

    // Restart the clear partway through with stored data present.
    @(negedge clk); rst = 1'b0;
    #2;
    chk("rst_mid_op_busy", 32'(Busy), 1);
    chk("rst_mid_op_data_out", Data_out, 0);
    @(negedge clk); rst = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < Depth; i++) mem_m[i] = 8'h00;
    @(negedge clk); rst = 1'b1;
    count_busy("busy_cycles_restart");
    for (int w = 0; w < Depth / 4; w++) issue(0, 1, Base + 32'(4 * w), 0, 2'b10, 0);
    idle(2);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
